// File: rtl/inch_pkg.sv
// Shared widths, flit-type codes and VC state encoding for the router input channel.
package inch_pkg;

    localparam int DATAW = 31;
    localparam int VCHW  = 0;
    localparam int PORTW = 2;
    localparam int PORT  = 4;

    typedef logic [DATAW:0] flit_t;
    typedef logic [1:0]     ftype_t;
    typedef logic [PORTW:0] port_t;
    typedef logic [VCHW:0]  vc_t;

    localparam ftype_t FT_HEAD = 2'b01;
    localparam ftype_t FT_BODY = 2'b00;
    localparam ftype_t FT_TAIL = 2'b10;
    localparam ftype_t FT_HT   = 2'b11;

    typedef enum logic [1:0] {
        VC_IDLE   = 2'd0,
        VC_ROUTED = 2'd1,
        VC_ACTIVE = 2'd2
    } vc_st_e;

    function automatic logic is_head(input ftype_t t);
        return t inside {FT_HEAD, FT_HT};
    endfunction

    function automatic logic is_tail(input ftype_t t);
        return t inside {FT_TAIL, FT_HT};
    endfunction

endpackage

// File: rtl/inch_fifo.sv
// Per-VC flit FIFO, DEPTH entries (power of two), head visible combinationally.
module inch_fifo
    import inch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_,
    input  logic  push,
    input  logic  pop,
    input  flit_t data,
    output flit_t head,
    output logic  empty,
    output logic  full
);

    localparam int AW = $clog2(DEPTH);

    flit_t         r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr] <= data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (push && !pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (pop && !push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign head  = r_mem[r_rd];
    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == (AW+1)'(DEPTH));

endmodule

// File: rtl/inch.sv
// Router input channel: per-VC FIFOs, VC FSMs, round-robin VC select, grant decode, credits.
// Define INCH_OVF_CHK_EN to enable the sticky overflow check (ovf_err).
module inch
    import inch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int VCH   = 2
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic [DATAW:0] idata,
    input  logic           ivalid,
    input  logic [VCHW:0]  ivch,
    output logic [DATAW:0] odata,
    output logic           ovalid,
    output logic [VCHW:0]  ovch,
    output logic [PORTW:0] port,
    output logic           req,
    input  logic [PORT:0]  grt,
    output logic           ocredit,
    output logic [VCHW:0]  ocredit_vc,
    output logic           ovf_err
);

    localparam int GW = 2 ** (PORTW + 1);

    flit_t          w_head   [VCH];
    vc_st_e         r_st     [VCH];
    vc_st_e         w_st_nxt [VCH];
    port_t          r_port_q [VCH];
    logic [VCH-1:0] w_empty;
    logic [VCH-1:0] w_full;
    logic [VCH-1:0] w_wr;
    logic [VCH-1:0] w_push;
    logic [VCH-1:0] w_pop;
    logic [VCH-1:0] w_elig;
    vc_t            r_rr;
    vc_t            r_cur;
    vc_t            w_sel;
    vc_t            w_idx;
    logic           w_sel_vld;
    logic           w_req;
    logic           w_gnt;
    logic           w_tail;
    logic [GW-1:0]  w_grt;
    logic           r_credit;
    vc_t            r_credit_vc;

    for (genvar v = 0; v < VCH; v++) begin : g_vc
        assign w_wr[v] = ivalid && (ivch == vc_t'(v));
`ifdef INCH_OVF_CHK_EN
        assign w_push[v] = w_wr[v] && (!w_full[v] || w_pop[v]);
`else
        assign w_push[v] = w_wr[v];
`endif
        assign w_pop[v]  = w_gnt && (w_sel == vc_t'(v));
        assign w_elig[v] = (r_st[v] != VC_IDLE) && !w_empty[v];

        inch_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_  (rst_),
            .push  (w_push[v]),
            .pop   (w_pop[v]),
            .data  (idata),
            .head  (w_head[v]),
            .empty (w_empty[v]),
            .full  (w_full[v])
        );
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            for (int v = 0; v < VCH; v++) begin
                r_st[v]     <= VC_IDLE;
                r_port_q[v] <= '0;
            end
        end else begin
            for (int v = 0; v < VCH; v++) begin
                r_st[v] <= w_st_nxt[v];
                if (r_st[v] == VC_IDLE && w_st_nxt[v] == VC_ROUTED) begin
                    r_port_q[v] <= w_head[v][PORTW:0];
                end
            end
        end
    end

    // A VC only leaves IDLE on a head flit; stray body/tail flits stall it.
    always_comb begin
        for (int v = 0; v < VCH; v++) begin
            w_st_nxt[v] = r_st[v];
            unique case (r_st[v])
                VC_IDLE: begin
                    if (!w_empty[v] && is_head(w_head[v][DATAW:DATAW-1])) begin
                        w_st_nxt[v] = VC_ROUTED;
                    end
                end
                VC_ROUTED: begin
                    if (w_pop[v]) begin
                        w_st_nxt[v] = is_tail(w_head[v][DATAW:DATAW-1])
                                    ? VC_IDLE : VC_ACTIVE;
                    end
                end
                VC_ACTIVE: begin
                    if (w_pop[v] && is_tail(w_head[v][DATAW:DATAW-1])) begin
                        w_st_nxt[v] = VC_IDLE;
                    end
                end
                default: w_st_nxt[v] = VC_IDLE;
            endcase
        end
    end

    // Hold the current VC for the whole packet; otherwise search from r_rr.
    always_comb begin
        w_sel     = r_rr;
        w_sel_vld = 1'b0;
        w_idx     = r_rr;
        if (r_st[r_cur] == VC_ACTIVE) begin
            w_sel     = r_cur;
            w_sel_vld = 1'b1;
        end else begin
            for (int i = VCH - 1; i >= 0; i--) begin
                w_idx = r_rr + vc_t'(i);
                if (w_elig[w_idx]) begin
                    w_sel     = w_idx;
                    w_sel_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_grt         = '0;
        w_grt[PORT:0] = grt;
    end

    assign w_req  = w_sel_vld && !w_empty[w_sel];
    assign port   = w_req ? r_port_q[w_sel] : '0;
    assign w_gnt  = w_req && w_grt[port];
    assign w_tail = is_tail(w_head[w_sel][DATAW:DATAW-1]);

    assign req    = w_req;
    assign ovalid = w_gnt;
    assign odata  = w_gnt ? w_head[w_sel] : '0;
    assign ovch   = w_gnt ? w_sel : '0;

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_rr        <= '0;
            r_cur       <= '0;
            r_credit    <= 1'b0;
            r_credit_vc <= '0;
        end else begin
            r_cur       <= w_sel;
            r_credit    <= w_gnt;
            r_credit_vc <= w_gnt ? w_sel : '0;
            if (w_gnt && w_tail) begin
                r_rr <= w_sel + 1'b1;
            end
        end
    end

    assign ocredit    = r_credit;
    assign ocredit_vc = r_credit_vc;

`ifdef INCH_OVF_CHK_EN
    logic r_ovf;

    // A push to a full VC that is popped in the same cycle is not an overflow.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_ovf <= 1'b0;
        end else if (|(w_wr & w_full & ~w_pop)) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf_err = r_ovf;
`else
    logic w_unused_full;
    assign w_unused_full = |w_full;
    assign ovf_err       = 1'b0;
`endif

endmodule

// File: tb/tb_inch.sv
// Directed table-driven bench for the router input channel.
module tb_inch;
    import inch_pkg::*;

    typedef struct packed {
        logic        req;
        logic [2:0]  port;
        logic        ov;
        logic        ovch;
        logic [31:0] od;
        logic        cr;
        logic        cv;
        logic        ovf;
    } out_t;

    typedef struct packed {
        logic        iv;
        logic        vc;
        logic [31:0] d;
        logic [4:0]  g;
        out_t        e;
    } vec_t;

    logic           clk;
    logic           rst_;
    logic [DATAW:0] idata;
    logic           ivalid;
    logic [VCHW:0]  ivch;
    logic [DATAW:0] odata;
    logic           ovalid;
    logic [VCHW:0]  ovch;
    logic [PORTW:0] port;
    logic           req;
    logic [PORT:0]  grt;
    logic           ocredit;
    logic [VCHW:0]  ocredit_vc;
    logic           ovf_err;

    int n_cmp;
    int n_err;

    inch #(
        .DEPTH (4),
        .VCH   (2)
    ) dut (
        .clk        (clk),
        .rst_       (rst_),
        .idata      (idata),
        .ivalid     (ivalid),
        .ivch       (ivch),
        .odata      (odata),
        .ovalid     (ovalid),
        .ovch       (ovch),
        .port       (port),
        .req        (req),
        .grt        (grt),
        .ocredit    (ocredit),
        .ocredit_vc (ocredit_vc),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [1:0] ft,
                                       input logic [7:0] tag,
                                       input logic [2:0] p);
        return {ft, 19'd0, tag, p};
    endfunction

    function automatic vec_t V(input logic iv, input logic vc,
                               input logic [31:0] d, input logic [4:0] g,
                               input logic rq, input logic [2:0] pt,
                               input logic ov, input logic oc,
                               input logic [31:0] od, input logic cr,
                               input logic cv, input logic of);
        vec_t r;
        r.iv     = iv;
        r.vc     = vc;
        r.d      = d;
        r.g      = g;
        r.e.req  = rq;
        r.e.port = pt;
        r.e.ov   = ov;
        r.e.ovch = oc;
        r.e.od   = od;
        r.e.cr   = cr;
        r.e.cv   = cv;
        r.e.ovf  = of;
        return r;
    endfunction

    function automatic out_t sample();
        return {req, port, ovalid, ovch, odata, ocredit, ocredit_vc, ovf_err};
    endfunction

    task automatic run(input vec_t v, input int idx);
        out_t got;
        @(negedge clk);
        ivalid = v.iv;
        ivch   = v.vc;
        idata  = v.d;
        grt    = v.g;
        #1;
        got = sample();
        n_cmp++;
        if (got !== v.e) begin
            n_err++;
            $display("FAIL vec%0d: got %h required %h", idx, got, v.e);
        end
    endtask

    vec_t q[$];
    vec_t qr[$];
    vec_t qo[$];
    out_t got;
    logic [31:0] f01, f02, f10, f11, f12, f13, f20;
    logic [31:0] f30, f31, f40, f41, f50, f51, f52, f53, f54;
    logic [31:0] f60, f61, f62, f63, f70;
    logic [31:0] f80, f81, f82, f83, f84;

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_   = 1'b1;
        ivalid = 1'b0;
        ivch   = '0;
        idata  = '0;
        grt    = '0;

        f01 = mk(FT_HT,   8'h01, 3'd2);
        f02 = mk(FT_HT,   8'h02, 3'd3);
        f10 = mk(FT_HEAD, 8'h10, 3'd1);
        f11 = mk(FT_BODY, 8'h11, 3'd0);
        f12 = mk(FT_BODY, 8'h12, 3'd0);
        f13 = mk(FT_TAIL, 8'h13, 3'd0);
        f20 = mk(FT_HT,   8'h20, 3'd3);
        f30 = mk(FT_HT,   8'h30, 3'd1);
        f31 = mk(FT_HT,   8'h31, 3'd1);
        f40 = mk(FT_HT,   8'h40, 3'd2);
        f41 = mk(FT_HT,   8'h41, 3'd2);
        f50 = mk(FT_HEAD, 8'h50, 3'd4);
        f51 = mk(FT_BODY, 8'h51, 3'd0);
        f52 = mk(FT_BODY, 8'h52, 3'd0);
        f53 = mk(FT_TAIL, 8'h53, 3'd0);
        f54 = mk(FT_HT,   8'h54, 3'd4);
        f60 = mk(FT_HEAD, 8'h60, 3'd1);
        f61 = mk(FT_BODY, 8'h61, 3'd0);
        f62 = mk(FT_BODY, 8'h62, 3'd0);
        f63 = mk(FT_TAIL, 8'h63, 3'd0);
        f70 = mk(FT_HT,   8'h70, 3'd2);
        f80 = mk(FT_HEAD, 8'h80, 3'd4);
        f81 = mk(FT_BODY, 8'h81, 3'd0);
        f82 = mk(FT_BODY, 8'h82, 3'd0);
        f83 = mk(FT_TAIL, 8'h83, 3'd0);
        f84 = mk(FT_HT,   8'h84, 3'd4);

        // reset state, then head+tail port 2 on VC0
        q.push_back(V(0, 0, 0,   5'h00, 0, 0, 0, 0, 0,   0, 0, 0));
        q.push_back(V(1, 0, f01, 5'h00, 0, 0, 0, 0, 0,   0, 0, 0));
        q.push_back(V(0, 0, 0,   5'h00, 0, 0, 0, 0, 0,   0, 0, 0));
        q.push_back(V(0, 0, 0,   5'h00, 1, 2, 0, 0, 0,   0, 0, 0));
        q.push_back(V(0, 0, 0,   5'h04, 1, 2, 1, 0, f01, 0, 0, 0));
        q.push_back(V(0, 0, 0,   5'h00, 0, 0, 0, 0, 0,   1, 0, 0));
        // single-flit packet on VC1, port 3
        q.push_back(V(1, 1, f02, 5'h00, 0, 0, 0, 0, 0,   0, 0, 0));
        q.push_back(V(0, 0, 0,   5'h00, 0, 0, 0, 0, 0,   0, 0, 0));
        q.push_back(V(0, 0, 0,   5'h08, 1, 3, 1, 1, f02, 0, 0, 0));
        q.push_back(V(0, 0, 0,   5'h00, 0, 0, 0, 0, 0,   1, 1, 0));
        // 4-flit packet VC0 port 1, grant withheld, VC1 head waiting
        q.push_back(V(1, 0, f10, 5'h00, 0, 0, 0, 0, 0,   0, 0, 0));
        q.push_back(V(1, 0, f11, 5'h00, 0, 0, 0, 0, 0,   0, 0, 0));
        q.push_back(V(1, 0, f12, 5'h00, 1, 1, 0, 0, 0,   0, 0, 0));
        q.push_back(V(1, 0, f13, 5'h00, 1, 1, 0, 0, 0,   0, 0, 0));
        q.push_back(V(1, 1, f20, 5'h0a, 1, 1, 1, 0, f10, 0, 0, 0));
        q.push_back(V(0, 0, 0,   5'h02, 1, 1, 1, 0, f11, 1, 0, 0));
        q.push_back(V(0, 0, 0,   5'h02, 1, 1, 1, 0, f12, 1, 0, 0));
        q.push_back(V(0, 0, 0,   5'h0a, 1, 1, 1, 0, f13, 1, 0, 0));
        q.push_back(V(0, 0, 0,   5'h00, 1, 3, 0, 0, 0,   1, 0, 0));
        q.push_back(V(0, 0, 0,   5'h08, 1, 3, 1, 1, f20, 0, 0, 0));
        q.push_back(V(0, 0, 0,   5'h00, 0, 0, 0, 0, 0,   1, 1, 0));
        // fairness: two single-flit packets per VC, constant grants
        q.push_back(V(1, 0, f30, 5'h1f, 0, 0, 0, 0, 0,   0, 0, 0));
        q.push_back(V(1, 1, f40, 5'h1f, 0, 0, 0, 0, 0,   0, 0, 0));
        q.push_back(V(1, 0, f31, 5'h1f, 1, 1, 1, 0, f30, 0, 0, 0));
        q.push_back(V(1, 1, f41, 5'h1f, 1, 2, 1, 1, f40, 1, 0, 0));
        q.push_back(V(0, 0, 0,   5'h1f, 1, 1, 1, 0, f31, 1, 1, 0));
        q.push_back(V(0, 0, 0,   5'h1f, 1, 2, 1, 1, f41, 1, 0, 0));
        q.push_back(V(0, 0, 0,   5'h00, 0, 0, 0, 0, 0,   1, 1, 0));
        // VC1 full, then push + granted pop in the same cycle
        q.push_back(V(1, 1, f50, 5'h00, 0, 0, 0, 0, 0,   0, 0, 0));
        q.push_back(V(1, 1, f51, 5'h00, 0, 0, 0, 0, 0,   0, 0, 0));
        q.push_back(V(1, 1, f52, 5'h00, 1, 4, 0, 0, 0,   0, 0, 0));
        q.push_back(V(1, 1, f53, 5'h00, 1, 4, 0, 0, 0,   0, 0, 0));
        q.push_back(V(1, 1, f54, 5'h10, 1, 4, 1, 1, f50, 0, 0, 0));
        q.push_back(V(0, 0, 0,   5'h10, 1, 4, 1, 1, f51, 1, 1, 0));
        q.push_back(V(0, 0, 0,   5'h10, 1, 4, 1, 1, f52, 1, 1, 0));
        q.push_back(V(0, 0, 0,   5'h10, 1, 4, 1, 1, f53, 1, 1, 0));
        q.push_back(V(0, 0, 0,   5'h10, 0, 0, 0, 0, 0,   1, 1, 0));
        q.push_back(V(0, 0, 0,   5'h10, 1, 4, 1, 1, f54, 0, 0, 0));
        q.push_back(V(0, 0, 0,   5'h00, 0, 0, 0, 0, 0,   1, 1, 0));

        // mid-packet reset: first part, then recovery
        qr.push_back(V(1, 0, f60, 5'h00, 0, 0, 0, 0, 0,   0, 0, 0));
        qr.push_back(V(1, 0, f61, 5'h00, 0, 0, 0, 0, 0,   0, 0, 0));
        qr.push_back(V(1, 0, f62, 5'h02, 1, 1, 1, 0, f60, 0, 0, 0));
        qr.push_back(V(1, 0, f63, 5'h02, 1, 1, 1, 0, f61, 1, 0, 0));
        qr.push_back(V(0, 0, 0,   5'h02, 1, 1, 1, 0, f62, 1, 0, 0));
        qr.push_back(V(0, 0, 0,   5'h02, 0, 0, 0, 0, 0,   0, 0, 0));
        qr.push_back(V(1, 0, f70, 5'h04, 0, 0, 0, 0, 0,   0, 0, 0));
        qr.push_back(V(0, 0, 0,   5'h04, 0, 0, 0, 0, 0,   0, 0, 0));
        qr.push_back(V(0, 0, 0,   5'h04, 1, 2, 1, 0, f70, 0, 0, 0));
        qr.push_back(V(0, 0, 0,   5'h00, 0, 0, 0, 0, 0,   1, 0, 0));

        // overflow: extra push to full VC1 is dropped and flagged
        qo.push_back(V(1, 1, f80, 5'h00, 0, 0, 0, 0, 0,   0, 0, 0));
        qo.push_back(V(1, 1, f81, 5'h00, 0, 0, 0, 0, 0,   0, 0, 0));
        qo.push_back(V(1, 1, f82, 5'h00, 1, 4, 0, 0, 0,   0, 0, 0));
        qo.push_back(V(1, 1, f83, 5'h00, 1, 4, 0, 0, 0,   0, 0, 0));
        qo.push_back(V(1, 1, f84, 5'h00, 1, 4, 0, 0, 0,   0, 0, 0));
        qo.push_back(V(0, 0, 0,   5'h00, 1, 4, 0, 0, 0,   0, 0, 1));
        qo.push_back(V(0, 0, 0,   5'h10, 1, 4, 1, 1, f80, 0, 0, 1));
        qo.push_back(V(0, 0, 0,   5'h10, 1, 4, 1, 1, f81, 1, 1, 1));
        qo.push_back(V(0, 0, 0,   5'h10, 1, 4, 1, 1, f82, 1, 1, 1));
        qo.push_back(V(0, 0, 0,   5'h10, 1, 4, 1, 1, f83, 1, 1, 1));
        qo.push_back(V(0, 0, 0,   5'h10, 0, 0, 0, 0, 0,   1, 1, 1));
        qo.push_back(V(0, 0, 0,   5'h10, 0, 0, 0, 0, 0,   0, 0, 1));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ = 1'b0;

        foreach (q[i]) begin
            run(q[i], i);
        end

        for (int i = 0; i < 5; i++) begin
            run(qr[i], 100 + i);
        end
        #2 rst_ = 1'b1;
        #1;
        got = sample();
        n_cmp++;
        if (got !== '0) begin
            n_err++;
            $display("FAIL async_rst: got %h required 0", got);
        end
        @(negedge clk);
        rst_   = 1'b0;
        ivalid = 1'b0;
        for (int i = 5; i < 10; i++) begin
            run(qr[i], 100 + i);
        end

`ifdef INCH_OVF_CHK_EN
        foreach (qo[i]) begin
            run(qo[i], 200 + i);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
